// File: rtl/divmod_feeder.sv
// divmod_feeder
// Operand dispatcher in front of the 8-bit sequential divider. Jobs are
// buffered in a small circular FIFO. They are issued to the divider one at a
// time with a single-cycle start pulse. Results go to the consumer under a
// valid/ready handshake. Divide-by-zero jobs are resolved locally and never
// reach the divider.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        job handshake; in_dividend/in_divisor operands
//   div_valid                start pulse to the divider
//   div_dividend/div_divisor registered divider operands
//   div_done                 divider result pulse
//   div_quotient/remainder   divider result, valid with div_done
//   res_valid/res_ready      result handshake
//   res_quotient/remainder   held result
//   res_dbz                  result came from a zero divisor
//   count                    FIFO occupancy
//   busy                     a job is in flight (state != IDLE)
//
// state | meaning
// IDLE  | waiting for a queued job; pops the head when the FIFO is not empty
// ISSUE | div_valid asserted for exactly this cycle
// WAIT  | divider running; captures the result on div_done
// DONE  | result presented to the consumer until res_ready
module divmod_feeder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_dividend,
    input  logic [7:0]               in_divisor,
    output logic                     in_ready,
    output logic                     div_valid,
    output logic [7:0]               div_dividend,
    output logic [7:0]               div_divisor,
    input  logic                     div_done,
    input  logic [7:0]               div_quotient,
    input  logic [7:0]               div_remainder,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_quotient,
    output logic [7:0]               res_remainder,
    output logic                     res_dbz,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     mem_q [DEPTH];
    logic [15:0]     mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      div_dividend_q, div_dividend_d;
    logic [7:0]      div_divisor_q, div_divisor_d;
    logic [7:0]      res_quotient_q, res_quotient_d;
    logic [7:0]      res_remainder_q, res_remainder_d;
    logic            res_dbz_q, res_dbz_d;

    logic            push;
    logic            pop;
    logic [15:0]     head;

    assign in_ready      = (count_q != FULL);
    assign count         = count_q;
    assign busy          = (state_q != S_IDLE);
    assign div_valid     = (state_q == S_ISSUE);
    assign res_valid     = (state_q == S_DONE);
    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;
    assign res_quotient  = res_quotient_q;
    assign res_remainder = res_remainder_q;
    assign res_dbz       = res_dbz_q;

    // Entry layout: {dividend, divisor}
    assign head = mem_q[rd_ptr_q];
    assign push = in_valid && in_ready;

    always_comb begin
        state_d         = state_q;
        mem_d           = mem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        div_dividend_d  = div_dividend_q;
        div_divisor_d   = div_divisor_q;
        res_quotient_d  = res_quotient_q;
        res_remainder_d = res_remainder_q;
        res_dbz_d       = res_dbz_q;
        pop             = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head[7:0] != 8'h00) begin
                        div_dividend_d = head[15:8];
                        div_divisor_d  = head[7:0];
                        state_d        = S_ISSUE;
                    end else begin
                        // Zero divisor: all-ones quotient, dividend as remainder.
                        res_quotient_d  = 8'hFF;
                        res_remainder_d = head[15:8];
                        res_dbz_d       = 1'b1;
                        state_d         = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (div_done) begin
                    res_quotient_d  = div_quotient;
                    res_remainder_d = div_remainder;
                    res_dbz_d       = 1'b0;
                    state_d         = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = {in_dividend, in_divisor};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            div_dividend_q  <= 8'h00;
            div_divisor_q   <= 8'h00;
            res_quotient_q  <= 8'h00;
            res_remainder_q <= 8'h00;
            res_dbz_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            mem_q           <= mem_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            div_dividend_q  <= div_dividend_d;
            div_divisor_q   <= div_divisor_d;
            res_quotient_q  <= res_quotient_d;
            res_remainder_q <= res_remainder_d;
            res_dbz_q       <= res_dbz_d;
        end
    end

endmodule

// File: tb/tb_divmod_feeder.sv
module tb_divmod_feeder;

    localparam int DEPTH = 4;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic [7:0]              in_dividend;
    logic [7:0]              in_divisor;
    logic                    in_ready;
    logic                    div_valid;
    logic [7:0]              div_dividend;
    logic [7:0]              div_divisor;
    logic                    div_done;
    logic [7:0]              div_quotient;
    logic [7:0]              div_remainder;
    logic                    res_valid;
    logic                    res_ready;
    logic [7:0]              res_quotient;
    logic [7:0]              res_remainder;
    logic                    res_dbz;
    logic [$clog2(DEPTH):0]  count;
    logic                    busy;

    divmod_feeder #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .in_ready      (in_ready),
        .div_valid     (div_valid),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_quotient  (res_quotient),
        .res_remainder (res_remainder),
        .res_dbz       (res_dbz),
        .count         (count),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
    } job_t;

    job_t src[$];   // jobs waiting to be offered
    job_t exp_q[$]; // accepted jobs whose results are not yet consumed, push order
    job_t nz_q[$];  // accepted jobs with nonzero divisor, not yet issued

    int n_checks = 0;
    int n_errors = 0;

    int p_in = 0;
    int p_rdy = 0;
    int lat_min = 1;
    int lat_max = 1;
    bit stall = 0;
    bit stray = 0;

    bit         dv_busy = 0;
    int         dv_cnt = 0;
    logic [7:0] dv_q, dv_r;
    int         n_issue = 0;
    int         n_deliv = 0;

    bit         prev_hold = 0;
    bit         prev_idle_nonempty = 0;
    bit         prev_div_valid = 0;
    logic [7:0] prev_q, prev_r;
    logic       prev_dbz;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event not expected (got 1, expected 0)", name);
    endtask

    // One cycle: sample and check outputs at the falling edge, then update the
    // reference model with the handshakes that will happen at the next rising
    // edge and drive the inputs for it.
    task automatic step();
        job_t j;
        int   mc;
        @(negedge clk);

        mc = exp_q.size() - int'(busy);
        chk("count", int'(count), mc);
        chk("in_ready", int'(in_ready), int'(mc != DEPTH));
        if (res_valid || div_valid) chk("busy_with_output", int'(busy), 1);
        if (prev_idle_nonempty) chk("idle_pops_head", int'(busy), 1);
        if (prev_div_valid) chk("div_valid_one_cycle", int'(div_valid), 0);
        if (prev_hold) begin
            chk("hold_valid", int'(res_valid), 1);
            chk("hold_quotient", int'(res_quotient), int'(prev_q));
            chk("hold_remainder", int'(res_remainder), int'(prev_r));
            chk("hold_dbz", int'(res_dbz), int'(prev_dbz));
        end
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                fail("res_spurious");
            end else begin
                j = exp_q[0];
                if (j.b == 8'h00) begin
                    chk("res_quotient", int'(res_quotient), 255);
                    chk("res_remainder", int'(res_remainder), int'(j.a));
                    chk("res_dbz", int'(res_dbz), 1);
                end else begin
                    chk("res_quotient", int'(res_quotient), int'(j.a) / int'(j.b));
                    chk("res_remainder", int'(res_remainder), int'(j.a) % int'(j.b));
                    chk("res_dbz", int'(res_dbz), 0);
                end
            end
        end

        res_ready = ($urandom_range(99) < p_rdy);
        if (res_valid && res_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            n_deliv++;
        end

        in_valid = 1'b0;
        in_dividend = 8'($urandom);
        in_divisor = 8'($urandom);
        if (src.size() > 0 && $urandom_range(99) < p_in) begin
            in_valid = 1'b1;
            in_dividend = src[0].a;
            in_divisor = src[0].b;
        end
        if (in_valid && in_ready) begin
            j = src.pop_front();
            exp_q.push_back(j);
            if (j.b != 8'h00) nz_q.push_back(j);
        end

        div_done = 1'b0;
        div_quotient = 8'h00;
        div_remainder = 8'h00;
        if (dv_busy && !stall) begin
            dv_cnt--;
            if (dv_cnt <= 0) begin
                div_done = 1'b1;
                div_quotient = dv_q;
                div_remainder = dv_r;
                dv_busy = 0;
            end
        end
        if (div_valid) begin
            n_issue++;
            if (dv_busy) fail("div_overlap");
            if (nz_q.size() == 0) begin
                fail("div_spurious_issue");
            end else begin
                j = nz_q.pop_front();
                chk("div_dividend", int'(div_dividend), int'(j.a));
                chk("div_divisor", int'(div_divisor), int'(j.b));
                dv_q = 8'(int'(j.a) / int'(j.b));
                dv_r = 8'(int'(j.a) % int'(j.b));
                dv_busy = 1;
                dv_cnt = int'($urandom_range(lat_max, lat_min));
            end
        end
        if (stray && !div_done) begin
            div_done = 1'b1;
            div_quotient = 8'hAA;
            div_remainder = 8'h55;
        end

        prev_hold = res_valid && !res_ready;
        prev_q = res_quotient;
        prev_r = res_remainder;
        prev_dbz = res_dbz;
        prev_idle_nonempty = !busy && (count != '0);
        prev_div_valid = div_valid;
    endtask

    task automatic drain(input string name, input int max_cyc);
        int k;
        p_rdy = 100;
        stall = 0;
        stray = 0;
        k = 0;
        while (k < max_cyc && (exp_q.size() != 0 || src.size() != 0 || busy)) begin
            step();
            k++;
        end
        chk(name, exp_q.size() + src.size() + int'(busy), 0);
        p_rdy = 0;
    endtask

    task automatic wait_res(input string name, input int max_cyc);
        int k;
        k = 0;
        while (k < max_cyc && !res_valid) begin
            step();
            k++;
        end
        chk(name, int'(res_valid), 1);
    endtask

    initial begin
        int k, base_issue, base_deliv;
        job_t j;

        rst = 1'b1;
        in_valid = 1'b0;
        in_dividend = 8'h00;
        in_divisor = 8'h00;
        div_done = 1'b0;
        div_quotient = 8'h00;
        div_remainder = 8'h00;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_count", int'(count), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_div_valid", int'(div_valid), 0);
        chk("rst_div_dividend", int'(div_dividend), 0);
        chk("rst_res_quotient", int'(res_quotient), 0);
        chk("rst_res_dbz", int'(res_dbz), 0);
        rst = 1'b0;

        // Single job 100/7
        lat_min = 3; lat_max = 3; p_in = 100; p_rdy = 0;
        j.a = 8'd100; j.b = 8'd7; src.push_back(j);
        step();
        step();
        chk("t1_count_after_push", int'(count), 1);
        chk("t1_no_early_issue", int'(div_valid), 0);
        step();
        chk("t1_issue", int'(div_valid), 1);
        chk("t1_div_dividend", int'(div_dividend), 100);
        chk("t1_div_divisor", int'(div_divisor), 7);
        wait_res("t1_res_timeout", 20);
        chk("t1_quotient", int'(res_quotient), 14);
        chk("t1_remainder", int'(res_remainder), 2);
        chk("t1_dbz", int'(res_dbz), 0);
        repeat (3) step();
        chk("t1_held_valid", int'(res_valid), 1);
        chk("t1_held_quotient", int'(res_quotient), 14);
        drain("t1_drain", 20);

        // Divide by zero 200/0
        base_issue = n_issue;
        j.a = 8'd200; j.b = 8'd0; src.push_back(j);
        step();
        step();
        chk("dbz_not_yet_valid", int'(res_valid), 0);
        step();
        chk("dbz_valid", int'(res_valid), 1);
        chk("dbz_quotient", int'(res_quotient), 255);
        chk("dbz_remainder", int'(res_remainder), 200);
        chk("dbz_flag", int'(res_dbz), 1);
        repeat (2) step();
        chk("dbz_no_issue", n_issue - base_issue, 0);
        drain("dbz_drain", 20);

        // Five jobs back to back with a stalled divider
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            j.a = 8'(20 + 37 * i); j.b = 8'(i + 2); src.push_back(j);
        end
        k = 0;
        while (k < 15 && src.size() != 0) begin step(); k++; end
        step();
        chk("t2_full_count", int'(count), 4);
        chk("t2_full_in_ready", int'(in_ready), 0);
        j.a = 8'd255; j.b = 8'd16; src.push_back(j);
        repeat (4) step();
        chk("t2_still_full", int'(count), 4);
        drain("t2_drain", 100);

        // Consumer stalls in DONE; stray div_done; FIFO keeps accepting
        lat_min = 2; lat_max = 2;
        j.a = 8'd77; j.b = 8'd9; src.push_back(j);
        wait_res("t4_res_timeout", 20);
        base_issue = n_issue;
        for (int i = 0; i < 6; i++) begin
            j.a = 8'($urandom); j.b = 8'($urandom_range(255, 1)); src.push_back(j);
        end
        for (int i = 0; i < 10; i++) begin
            stray = (i % 3 == 1);
            step();
        end
        stray = 0;
        step();
        chk("t4_no_issue_in_done", n_issue - base_issue, 0);
        chk("t4_fifo_filled", int'(count), 4);
        chk("t4_still_valid", int'(res_valid), 1);
        src.delete();
        drain("t4_drain", 100);

        // Random stream through pointer wrap
        base_deliv = n_deliv;
        lat_min = 1; lat_max = 5; p_in = 60; p_rdy = 60;
        for (int i = 0; i < 40; i++) begin
            j.a = 8'($urandom);
            j.b = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
            src.push_back(j);
        end
        k = 0;
        while (k < 3000 && (exp_q.size() != 0 || src.size() != 0 || busy)) begin
            step();
            k++;
        end
        chk("t5_all_done", exp_q.size() + src.size(), 0);
        chk("t5_delivered", n_deliv - base_deliv, 40);
        chk("t5_count_zero", int'(count), 0);
        p_rdy = 0;

        // Reset mid-WAIT with three queued jobs
        stall = 1; p_in = 100; p_rdy = 100;
        for (int i = 0; i < 4; i++) begin
            j.a = 8'(50 + i); j.b = 8'(3 + i); src.push_back(j);
        end
        k = 0;
        while (k < 20 && !(busy && !div_valid && count == 3)) begin step(); k++; end
        chk("t6_reach_wait", int'(busy && !div_valid && count == 3), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_res_valid", int'(res_valid), 0);
        chk("t6_rst_div_valid", int'(div_valid), 0);
        chk("t6_rst_in_ready", int'(in_ready), 1);
        chk("t6_rst_busy", int'(busy), 0);
        src.delete(); exp_q.delete(); nz_q.delete();
        dv_busy = 0; stall = 0; p_in = 0;
        prev_hold = 0; prev_idle_nonempty = 0; prev_div_valid = 0;
        in_valid = 1'b0; div_done = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stray = 1;
        step();
        stray = 0;
        repeat (3) step();
        chk("t6_no_result_after_done", int'(res_valid), 0);
        chk("t6_idle_after", int'(busy), 0);
        chk("t6_count_after", int'(count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
